spike_encoder: RTL and testbench

SPIKE_ENCODER -- requirements
Module: spike_encoder

---
 rtl/snn_pkg.sv | 28 ++
 rtl/spike_lfsr.sv | 22 ++
 rtl/spike_encoder.sv | 137 +++++++++++++
 tb/tb_spike_encoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the spike encoder: FSM states, LFSR mask,
// default widths and LFSR helper functions.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } enc_state_t;

    localparam logic [15:0] LFSR_MASK          = 16'hB400;
    localparam int          DEF_NUM_INPUTS     = 4;
    localparam int          DEF_PIXEL_SIZE     = 8;
    localparam int          DEF_NUM_STEPS      = 16;
    localparam int          DEF_PIX_ADDR_WIDTH = 10;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    // All-zero is the lock-up state of a Galois LFSR, so it is never used as a seed.
    function automatic logic [15:0] lfsr_seed(input logic [15:0] base, input int idx);
        logic [15:0] s;
        s = base + 16'(idx);
        return (s == 16'd0) ? 16'd1 : s;
    endfunction

endpackage

// File: rtl/spike_lfsr.sv
// One 16-bit Galois LFSR with synchronous load and step enable.
module spike_lfsr
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        en,
    input  logic [15:0] seed,
    output logic [15:0] lfsr
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            lfsr <= 16'd1;
        else if (load)
            lfsr <= seed;
        else if (en)
            lfsr <= lfsr_step(lfsr);
    end

endmodule

// File: rtl/spike_encoder.sv
// Rate encoder: turns stored pixel intensities into spike trains over NUM_STEPS
// timesteps. Define SPIKE_ENCODER_LFSR_EN for stochastic (LFSR) encoding.
module spike_encoder
    import snn_pkg::*;
#(
    parameter int          NUM_INPUTS     = DEF_NUM_INPUTS,
    parameter int          PIXEL_SIZE     = DEF_PIXEL_SIZE,
    parameter int          NUM_STEPS      = DEF_NUM_STEPS,
    parameter int          PIX_ADDR_WIDTH = DEF_PIX_ADDR_WIDTH,
    parameter logic [15:0] SEED           = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PIX_ADDR_WIDTH-1:0] pix_addr,
    input  logic [PIXEL_SIZE-1:0]     pix_din,
    input  logic                      pix_wen,
    output logic [PIXEL_SIZE-1:0]     pix_dout,
    input  logic                      start,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_INPUTS-1:0]     spike_out,
    output logic                      spike_valid,
    output logic [15:0]               step
);

    localparam logic [16:0] STEPS_TOTAL = 17'(NUM_STEPS);

    enc_state_t state, next_state;
    logic [NUM_INPUTS-1:0][PIXEL_SIZE-1:0] pixel;
    logic [NUM_INPUTS-1:0]                 spike_calc;
    logic [16:0]                           cnt;
    logic                                  finished, launch, advance;

    // cnt counts emitted timesteps; RUN lingers one cycle after the last one
    // so done lands in the cycle right after the final spike_valid.
    assign finished = (cnt == STEPS_TOTAL);
    assign launch   = (state == IDLE) && start;
    assign advance  = (state == RUN) && !finished && !hold;
    assign busy     = (state == RUN);
    assign done     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (finished) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel <= '0;
        end else if (pix_wen && state != RUN) begin
            for (int i = 0; i < NUM_INPUTS; i++)
                if (pix_addr == PIX_ADDR_WIDTH'(i))
                    pixel[i] <= pix_din;
        end
    end

    always_comb begin
        pix_dout = '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            if (pix_addr == PIX_ADDR_WIDTH'(i))
                pix_dout = pixel[i];
    end

`ifdef SPIKE_ENCODER_LFSR_EN
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lfsr
        logic [15:0] lfsr_q;

        spike_lfsr u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .load (launch),
            .en   (advance),
            .seed (lfsr_seed(SEED, g)),
            .lfsr (lfsr_q)
        );

        assign spike_calc[g] = (lfsr_q[PIXEL_SIZE-1:0] < pixel[g]);
    end
`else
    logic [NUM_INPUTS-1:0][PIXEL_SIZE-1:0] acc;
    logic [NUM_INPUTS-1:0][PIXEL_SIZE:0]   acc_next;

    // Phase accumulator: the carry out fires at a rate of pixel / 2^PIXEL_SIZE.
    always_comb begin
        acc_next   = '0;
        spike_calc = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            acc_next[i]   = {1'b0, acc[i]} + {1'b0, pixel[i]};
            spike_calc[i] = acc_next[i][PIXEL_SIZE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (launch) begin
            acc <= '0;
        end else if (advance) begin
            for (int i = 0; i < NUM_INPUTS; i++)
                acc[i] <= acc_next[i][PIXEL_SIZE-1:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spike_valid <= 1'b0;
            spike_out   <= '0;
            step        <= 16'd0;
            cnt         <= 17'd0;
        end else begin
            spike_valid <= advance;
            spike_out   <= advance ? spike_calc : '0;
            if (launch) begin
                cnt  <= 17'd0;
                step <= 16'd0;
            end else if (advance) begin
                cnt  <= cnt + 17'd1;
                step <= cnt[15:0];
            end
        end
    end

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder: pixel memory vectors, fixed/hold/reset
// sequences and randomized runs against an arithmetic rate-coding model.
module tb_spike_encoder;

    localparam int          NI   = 4;
    localparam int          PS   = 8;
    localparam int          NS   = 16;
    localparam int          AW   = 10;
    localparam logic [15:0] SEED = 16'hACE1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] pix_addr = '0;
    logic [PS-1:0] pix_din = '0;
    logic          pix_wen = 1'b0;
    logic          start = 1'b0;
    logic          hold = 1'b0;
    logic [PS-1:0] pix_dout;
    logic          busy, done, spike_valid;
    logic [NI-1:0] spike_out;
    logic [15:0]   step;

    int            n_chk = 0;
    int            n_pass = 0;
    int            mem[NI];
    int            run_cnt[NI];
    logic [NI-1:0] run_seq[NS];

    spike_encoder #(
        .NUM_INPUTS(NI), .PIXEL_SIZE(PS), .NUM_STEPS(NS),
        .PIX_ADDR_WIDTH(AW), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .pix_addr(pix_addr), .pix_din(pix_din),
        .pix_wen(pix_wen), .pix_dout(pix_dout), .start(start), .hold(hold),
        .busy(busy), .done(done), .spike_out(spike_out),
        .spike_valid(spike_valid), .step(step)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected spike of channel ch at timestep k, from the rate-coding rule.
    function automatic bit ref_spike(input int ch, input int pix, input int k);
`ifdef SPIKE_ENCODER_LFSR_EN
        logic [15:0] v;
        v = SEED + 16'(ch);
        if (v == 16'd0) v = 16'd1;
        for (int j = 0; j < k; j++)
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        return int'(v[PS-1:0]) < pix;
`else
        return ((k + 1) * pix) / 256 > (k * pix) / 256;
`endif
    endfunction

    task automatic write_pix(input int addr, input int din);
        @(negedge clk);
        pix_addr = AW'(addr);
        pix_din  = PS'(din);
        pix_wen  = 1'b1;
        @(negedge clk);
        pix_wen = 1'b0;
        if (addr < NI) mem[addr] = din;
    endtask

    task automatic run_check(input string tag, input int hold_at, input int hold_len,
                             input bit wr_in_run);
        int  vcnt, held, cyc, done_cyc;
        bit  got_done;
        logic [NI-1:0] ev;
        vcnt = 0; held = 0; cyc = 0; done_cyc = -1; got_done = 0;
        for (int c = 0; c < NI; c++) run_cnt[c] = 0;
        pix_addr = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy_at_start"}, busy, 1);
        chk({tag, " valid_at_start"}, spike_valid, 0);
        while (!got_done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                chk({tag, " hold_valid"}, spike_valid, 0);
                chk({tag, " hold_spikes"}, spike_out, 0);
                chk({tag, " hold_step"}, step, hold_at);
                held++;
                if (held == hold_len) hold = 1'b0;
            end else if (spike_valid) begin
                ev = '0;
                for (int c = 0; c < NI; c++) begin
                    ev[c] = ref_spike(c, mem[c], vcnt);
                    if (spike_out[c]) run_cnt[c]++;
                end
                chk({tag, " spike_out"}, spike_out, ev);
                chk({tag, " step"}, step, vcnt);
                if (vcnt < NS) run_seq[vcnt] = spike_out;
                vcnt++;
                if (hold_len > 0 && held == 0 && int'(step) == hold_at) hold = 1'b1;
            end
            if (done) begin
                got_done = 1;
                done_cyc = cyc;
            end
            if (wr_in_run && cyc == 3) begin
                pix_addr = '0; pix_din = 8'hFF; pix_wen = 1'b1; start = 1'b1;
            end
            if (wr_in_run && cyc == 4) begin
                chk({tag, " dout_after_run_write"}, pix_dout, mem[0]);
                pix_wen = 1'b0; start = 1'b0;
            end
        end
        hold = 1'b0;
        chk({tag, " done_seen"}, got_done, 1);
        chk({tag, " done_cycle"}, done_cyc, NS + hold_len + 1);
        chk({tag, " valid_count"}, vcnt, NS);
        @(negedge clk);
        chk({tag, " busy_after"}, busy, 0);
        chk({tag, " done_after"}, done, 0);
    endtask

    typedef struct {
        int addr;
        int din;
        int exp;
    } vec_t;

    vec_t tv[6];
    int   cnt_exp[NI];
    logic [NI-1:0] seq_a[NS];
    int   no_done;
    int   hit;

    initial begin
        tv[0] = '{0, 0, 0};
        tv[1] = '{1, 64, 64};
        tv[2] = '{2, 128, 128};
        tv[3] = '{3, 255, 255};
        tv[4] = '{7, 8'hAA, 0};
        tv[5] = '{4, 8'h5A, 0};
        cnt_exp = '{0, 4, 8, 15};
        for (int c = 0; c < NI; c++) mem[c] = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst valid", spike_valid, 0);
        chk("rst spikes", spike_out, 0);
        chk("rst step", step, 0);
        chk("rst dout", pix_dout, 0);
        rst = 1'b1;

        // Pixel memory writes/reads, including out-of-range addresses
        for (int i = 0; i < 6; i++) begin
            write_pix(tv[i].addr, tv[i].din);
            pix_addr = AW'(tv[i].addr);
            #1;
            chk($sformatf("mem vec%0d", i), pix_dout, tv[i].exp);
        end

        run_check("fixed", -1, 0, 0);
`ifndef SPIKE_ENCODER_LFSR_EN
        for (int c = 0; c < NI; c++)
            chk($sformatf("fixed count ch%0d", c), run_cnt[c], cnt_exp[c]);
`endif

        run_check("hold", 5, 3, 0);
        run_check("wr_run", -1, 0, 1);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (spike_valid && step == 16'd8) hit = 1;
        end
        chk("midrst reached step8", hit, 1);
        rst = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst valid", spike_valid, 0);
        chk("midrst spikes", spike_out, 0);
        chk("midrst step", step, 0);
        pix_addr = '0;
        #1;
        chk("midrst dout", pix_dout, 0);
        for (int c = 0; c < NI; c++) mem[c] = 0;
        @(negedge clk);
        rst = 1'b1;
        no_done = 1;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) no_done = 0;
        end
        chk("midrst no_done_after", no_done, 1);
        for (int i = 0; i < NI; i++) write_pix(tv[i].addr, tv[i].din);
        run_check("after_rst", -1, 0, 0);

        // Randomized pixels and hold placement
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NI; c++) write_pix(c, $urandom_range(0, 255));
            run_check($sformatf("rand%0d", r), $urandom_range(0, 14), $urandom_range(0, 4), 0);
        end

`ifdef SPIKE_ENCODER_LFSR_EN
        for (int i = 0; i < NI; i++) write_pix(tv[i].addr, tv[i].din);
        run_check("lfsr_a", -1, 0, 0);
        for (int k = 0; k < NS; k++) seq_a[k] = run_seq[k];
        chk("lfsr pix255 >=14", run_cnt[3] >= 14, 1);
        run_check("lfsr_b", -1, 0, 0);
        for (int k = 0; k < NS; k++)
            chk($sformatf("lfsr repeat step%0d", k), run_seq[k], seq_a[k]);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
